// File: rtl/cursor_nav_if.sv
// Button, load and cursor signals between the board I/O side and cursor_nav.
// The master modport drives buttons and the load port; the slave modport is the cursor logic.
interface cursor_nav_if #(
  parameter int CW = 9,
  parameter int RW = 9
);
  logic [3:0]    btn_in;
  logic          load_in;
  logic [11:0]   load_x_in;
  logic [11:0]   load_y_in;
  logic [CW-1:0] cursor_x_out;
  logic [RW-1:0] cursor_y_out;
  logic          moved_out;
  logic [3:0]    held_out;

  modport master (
    output btn_in, load_in, load_x_in, load_y_in,
    input  cursor_x_out, cursor_y_out, moved_out, held_out
  );

  modport slave (
    input  btn_in, load_in, load_x_in, load_y_in,
    output cursor_x_out, cursor_y_out, moved_out, held_out
  );
endinterface

// File: rtl/cursor_nav.sv
// Board cursor: per-button debounce and press-wait-repeat, then saturating/wrapping x/y stepping
// with an absolute load port. Optional acceleration is enabled by defining CURSOR_ACCEL_EN.
module cursor_nav #(
  parameter int LOG_DEBOUNCE_COUNT = 20,
  parameter int LOG_WAIT_COUNT     = 25,
  parameter int LOG_REPEAT_COUNT   = 22,
  parameter int BOARD_W            = 512,
  parameter int BOARD_H            = 512,
  parameter int WRAP               = 0
) (
  input logic         clk_in,
  input logic         rst_in,
  cursor_nav_if.slave bus
);
  localparam int CW   = $clog2(BOARD_W);
  localparam int RW   = $clog2(BOARD_H);
  localparam int CNTW = (LOG_WAIT_COUNT > LOG_REPEAT_COUNT) ? LOG_WAIT_COUNT : LOG_REPEAT_COUNT;

  localparam logic [LOG_DEBOUNCE_COUNT-1:0] DEB_MAX = '1;
  localparam logic [CNTW-1:0] WAIT_MAX = CNTW'((1 << LOG_WAIT_COUNT) - 1);
  localparam logic [CNTW-1:0] REP_MAX  = CNTW'((1 << LOG_REPEAT_COUNT) - 1);

  localparam logic [CW:0]   X_MAX   = (CW+1)'(BOARD_W - 1);
  localparam logic [CW:0]   X_DIM   = (CW+1)'(BOARD_W);
  localparam logic [RW:0]   Y_MAX   = (RW+1)'(BOARD_H - 1);
  localparam logic [RW:0]   Y_DIM   = (RW+1)'(BOARD_H);
  localparam logic [CW-1:0] X_RESET = CW'(BOARD_W / 2);
  localparam logic [RW-1:0] Y_RESET = RW'(BOARD_H / 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } state_t;

  logic [3:0] pulse;
  logic [3:0] fast;
  logic [3:0] held;

  for (genvar g = 0; g < 4; g++) begin : g_chan
    logic                          cand;
    logic                          level;
    logic [LOG_DEBOUNCE_COUNT-1:0] deb_cnt;
    state_t                        state;
    state_t                        state_next;
    logic [CNTW-1:0]               cnt;
    logic [CNTW-1:0]               cnt_next;
    logic                          pulse_q;
    logic                          pulse_next;

    // The clean level only follows a raw value that has stayed put for the whole window.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        cand    <= 1'b0;
        level   <= 1'b0;
        deb_cnt <= '0;
      end else if (bus.btn_in[g] != cand) begin
        cand    <= bus.btn_in[g];
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        level <= cand;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_next;
        cnt     <= cnt_next;
        pulse_q <= pulse_next;
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pulse_next = 1'b0;
      if (!level) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            pulse_next = 1'b1;
            cnt_next   = '0;
            state_next = ST_WAIT;
          end
          ST_WAIT: begin
            if (cnt == WAIT_MAX) begin
              pulse_next = 1'b1;
              cnt_next   = '0;
              state_next = ST_REPEAT;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (cnt == REP_MAX) begin
              pulse_next = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        endcase
      end
    end

`ifdef CURSOR_ACCEL_EN
    logic [3:0] rep_cnt;
    logic [3:0] rep_next;
    logic       fast_q;
    logic       fast_next;

    // Only pulses emitted while already in REPEAT count; the 8th and later ones take a big step.
    always_comb begin
      rep_next  = rep_cnt;
      fast_next = 1'b0;
      if (state_next == ST_IDLE) begin
        rep_next = '0;
      end else if (state == ST_REPEAT && pulse_next) begin
        rep_next  = (rep_cnt == 4'd8) ? 4'd8 : rep_cnt + 4'd1;
        fast_next = (rep_next == 4'd8);
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        rep_cnt <= '0;
        fast_q  <= 1'b0;
      end else begin
        rep_cnt <= rep_next;
        fast_q  <= fast_next;
      end
    end

    assign fast[g] = fast_q;
`else
    assign fast[g] = 1'b0;
`endif

    assign pulse[g] = pulse_q;
    assign held[g]  = (state == ST_REPEAT);
  end

  logic [CW-1:0] cursor_x;
  logic [RW-1:0] cursor_y;
  logic          moved;
  logic [CW:0]   x_ext;
  logic [CW:0]   x_step;
  logic [CW:0]   x_calc;
  logic [RW:0]   y_ext;
  logic [RW:0]   y_step;
  logic [RW:0]   y_calc;

  // One extra bit of headroom keeps edge detection exact for non-power-of-2 boards.
  always_comb begin
    x_ext  = {1'b0, cursor_x};
    y_ext  = {1'b0, cursor_y};
    x_calc = x_ext;
    y_calc = y_ext;
    x_step = (CW+1)'(1);
    y_step = (RW+1)'(1);

    if (pulse[0] && !pulse[1]) begin
      x_step = fast[0] ? (CW+1)'(4) : (CW+1)'(1);
      x_calc = x_ext + x_step;
      if (x_calc > X_MAX) x_calc = (WRAP != 0) ? x_calc - X_DIM : X_MAX;
    end else if (pulse[1] && !pulse[0]) begin
      x_step = fast[1] ? (CW+1)'(4) : (CW+1)'(1);
      if (x_ext < x_step) x_calc = (WRAP != 0) ? x_ext + X_DIM - x_step : '0;
      else                x_calc = x_ext - x_step;
    end

    if (pulse[3] && !pulse[2]) begin
      y_step = fast[3] ? (RW+1)'(4) : (RW+1)'(1);
      y_calc = y_ext + y_step;
      if (y_calc > Y_MAX) y_calc = (WRAP != 0) ? y_calc - Y_DIM : Y_MAX;
    end else if (pulse[2] && !pulse[3]) begin
      y_step = fast[2] ? (RW+1)'(4) : (RW+1)'(1);
      if (y_ext < y_step) y_calc = (WRAP != 0) ? y_ext + Y_DIM - y_step : '0;
      else                y_calc = y_ext - y_step;
    end

    // An absolute load wins over any button step arriving in the same cycle.
    if (bus.load_in) begin
      if ({20'd0, bus.load_x_in} > 32'(BOARD_W - 1)) x_calc = X_MAX;
      else                                           x_calc = {1'b0, bus.load_x_in[CW-1:0]};
      if ({20'd0, bus.load_y_in} > 32'(BOARD_H - 1)) y_calc = Y_MAX;
      else                                           y_calc = {1'b0, bus.load_y_in[RW-1:0]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cursor_x <= X_RESET;
      cursor_y <= Y_RESET;
      moved    <= 1'b0;
    end else begin
      cursor_x <= x_calc[CW-1:0];
      cursor_y <= y_calc[RW-1:0];
      moved    <= (x_calc[CW-1:0] != cursor_x) || (y_calc[RW-1:0] != cursor_y);
    end
  end

  assign bus.cursor_x_out = cursor_x;
  assign bus.cursor_y_out = cursor_y;
  assign bus.moved_out    = moved;
  assign bus.held_out     = held;
endmodule
